rpn_eval: RTL

Reverse-Polish expression engine that drives an internal LIFO from the issuing side: it accepts a token stream of operands and operator codes, pushes and pops its private stack, and emits results on request. It sits downstream of the token source and upstream of the result consumer. All stack traffic is generated here; no external push/pop exists.

---
 rtl/rpn_eval_if.sv | 26 ++
 rtl/rpn_eval.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rpn_eval_if.sv
// Token-in / result-out bundle for the RPN engine.
// The master side is the token source plus result consumer; the slave side is the engine.
interface rpn_eval_if #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 7
);
    logic             tok_valid;
    logic             tok_ready;
    logic             tok_is_op;
    logic [WIDTH-1:0] tok_data;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             err;
    logic [1:0]       err_code;
    logic [DEPTH:0]   depth;

    modport master (
        output tok_valid, tok_is_op, tok_data,
        input  tok_ready, res_valid, res_data, err, err_code, depth
    );

    modport slave (
        input  tok_valid, tok_is_op, tok_data,
        output tok_ready, res_valid, res_data, err, err_code, depth
    );
endinterface

// File: rtl/rpn_eval.sv
// Reverse-Polish evaluator with a private 2^DEPTH-entry LIFO.
// Operands push in one cycle; operators are latched and committed one cycle later in EXEC.
module rpn_eval #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 7
) (
    input logic        clk,
    input logic        reset,
    rpn_eval_if.slave  bus
);
    localparam int             ENTRIES = 2 ** DEPTH;
    localparam logic [DEPTH:0] FULL    = (DEPTH + 1)'(ENTRIES);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_DUP   = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_DROP  = 3'd5;
    localparam logic [2:0] OP_EMIT  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic [0:0] {IDLE, EXEC} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   stack [ENTRIES];
    logic [DEPTH:0]     sp, sp_next;
    logic [WIDTH-1:0]   op_word;

    logic               tok_ready;
    logic               res_valid_q, res_next;
    logic [WIDTH-1:0]   res_data_q, res_data_next;
    logic               err_q, err_next;
    logic [1:0]         err_code_q, code_next;

    logic               wr_en, swap_en;
    logic [DEPTH-1:0]   wr_idx, tos_idx, nos_idx;
    logic [WIDTH-1:0]   wr_data, tos, nos;
    logic [2:0]         opcode;
    logic               bad_op;

    function automatic logic [DEPTH:0] min_depth(input logic [2:0] op);
        case (op)
            OP_DUP, OP_DROP, OP_EMIT: min_depth = (DEPTH + 1)'(1);
            OP_CLEAR:                 min_depth = '0;
            default:                  min_depth = (DEPTH + 1)'(2);
        endcase
    endfunction

    assign tos_idx = sp[DEPTH-1:0] - DEPTH'(1);
    assign nos_idx = sp[DEPTH-1:0] - DEPTH'(2);
    assign tos     = stack[tos_idx];
    assign nos     = stack[nos_idx];
    assign opcode  = op_word[2:0];
    assign bad_op  = |op_word[WIDTH-1:3];

    always_comb begin
        state_next    = state;
        tok_ready     = (state == IDLE);
        sp_next       = sp;
        wr_en         = 1'b0;
        swap_en       = 1'b0;
        wr_idx        = sp[DEPTH-1:0];
        wr_data       = bus.tok_data;
        err_next      = 1'b0;
        code_next     = 2'd0;
        res_next      = 1'b0;
        res_data_next = res_data_q;

        case (state)
            IDLE: begin
                if (bus.tok_valid) begin
                    if (bus.tok_is_op) begin
                        state_next = EXEC;
                    end else if (sp == FULL) begin
                        err_next  = 1'b1;
                        code_next = 2'd1;
                    end else begin
                        wr_en   = 1'b1;
                        sp_next = sp + (DEPTH + 1)'(1);
                    end
                end
            end
            EXEC: begin
                state_next = IDLE;
                // Error priority: bad opcode, underflow, overflow; errors leave the stack untouched.
                if (bad_op) begin
                    err_next  = 1'b1;
                    code_next = 2'd3;
                end else if (sp < min_depth(opcode)) begin
                    err_next  = 1'b1;
                    code_next = 2'd2;
                end else if (opcode == OP_DUP && sp == FULL) begin
                    err_next  = 1'b1;
                    code_next = 2'd1;
                end else begin
                    case (opcode)
                        OP_ADD: begin
                            wr_en = 1'b1; wr_idx = nos_idx; wr_data = nos + tos;
                            sp_next = sp - (DEPTH + 1)'(1);
                        end
                        OP_SUB: begin
                            wr_en = 1'b1; wr_idx = nos_idx; wr_data = nos - tos;
                            sp_next = sp - (DEPTH + 1)'(1);
                        end
                        OP_MUL: begin
                            wr_en = 1'b1; wr_idx = nos_idx; wr_data = nos * tos;
                            sp_next = sp - (DEPTH + 1)'(1);
                        end
                        OP_DUP: begin
                            wr_en = 1'b1; wr_idx = sp[DEPTH-1:0]; wr_data = tos;
                            sp_next = sp + (DEPTH + 1)'(1);
                        end
                        OP_SWAP: begin
                            wr_en = 1'b1; wr_idx = nos_idx; wr_data = tos;
                            swap_en = 1'b1;
                        end
                        OP_DROP: sp_next = sp - (DEPTH + 1)'(1);
                        OP_EMIT: begin
                            sp_next       = sp - (DEPTH + 1)'(1);
                            res_next      = 1'b1;
                            res_data_next = tos;
                        end
                        default: sp_next = '0;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sp          <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state       <= state_next;
            sp          <= sp_next;
            res_valid_q <= res_next;
            res_data_q  <= res_data_next;
            err_q       <= err_next;
            err_code_q  <= code_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en)   stack[wr_idx]  <= wr_data;
            if (swap_en) stack[tos_idx] <= nos;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.tok_valid && bus.tok_is_op) op_word <= bus.tok_data;
    end

    assign bus.tok_ready = tok_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.depth     = sp;
endmodule
